uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// Oversampled UART receiver: start-bit validation, LSB-first data, optional parity,
// one or two checked stop bits, break hold-off and a single-word output holding register.
module uart_rx_core #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 sample_tick,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PEN       = (PARITY_EN != 0);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic [TW-1:0]          tick_q, tick_d, tick_adv;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   stop_err_q, stop_err_d;
  logic                   done;
  logic                   done_perr, done_ferr;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q, parity_err_q, frame_err_q, overrun_q;
  logic                   rxs;

  assign rxs      = sync_q[1];
  assign tick_adv = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    stop_err_d = stop_err_q;
    done       = 1'b0;
    done_ferr  = stop_err_q | ~rxs;
    done_perr  = PEN & ((^shift_q) ^ par_bit_q ^ ODD);

    unique case (state_q)
      S_IDLE: begin
        // Start detection is the only decision taken without a sample tick.
        if (!rxs) begin
          state_d = S_START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        if (sample_tick) begin
          if (tick_q == TICK_MID) begin
            state_d = rxs ? S_IDLE : S_DATA;
            tick_d  = '0;
          end else begin
            tick_d = tick_adv;
          end
        end
      end
      S_DATA: begin
        if (sample_tick) begin
          tick_d = tick_adv;
          if (tick_q == TICK_LAST) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            if (bit_q == DATA_LAST) begin
              state_d    = PEN ? S_PARITY : S_STOP;
              tick_d     = '0;
              bit_d      = '0;
              stop_err_d = 1'b0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
      end
      S_PARITY: begin
        if (sample_tick) begin
          tick_d = tick_adv;
          if (tick_q == TICK_LAST) begin
            par_bit_d  = rxs;
            state_d    = S_STOP;
            tick_d     = '0;
            bit_d      = '0;
            stop_err_d = 1'b0;
          end
        end
      end
      S_STOP: begin
        if (sample_tick) begin
          tick_d = tick_adv;
          if (tick_q == TICK_LAST) begin
            if (bit_q == STOP_LAST) begin
              // A low final stop bit means the line is still held: wait it out in BREAK.
              done    = 1'b1;
              state_d = rxs ? S_IDLE : S_BREAK;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              bit_d      = bit_q + BW'(1);
              stop_err_d = stop_err_q | ~rxs;
            end
          end
        end
      end
      S_BREAK: begin
        if (sample_tick && rxs) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_q     <= 2'b11;
      state_q    <= S_IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], rx};
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      stop_err_q <= stop_err_d;
    end
  end

  // Output holding register: a completion always wins over an ack in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else if (done) begin
      rx_data_q    <= shift_q;
      parity_err_q <= done_perr;
      frame_err_q  <= done_ferr;
      rx_valid_q   <= 1'b1;
      overrun_q    <= rx_valid_q & ~rx_ack;
    end else if (rx_ack && rx_valid_q) begin
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: three receiver configurations share one tick source;
// a serial driver pushes the expected word per frame and a monitor checks each delivered word.
module tb_uart_rx_core;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       sample_tick;
  logic [2:0] rx_line;
  logic [2:0] ack_auto, ack_man, ack_en, ack;
  logic [7:0] d0, d1;
  logic [8:0] d2;
  logic [2:0] valid, perr, ferr, ovr, busy;

  assign ack = ack_auto | ack_man;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clock(clock), .reset(reset), .rx(rx_line[0]), .sample_tick(sample_tick), .rx_ack(ack[0]),
    .rx_data(d0), .rx_valid(valid[0]), .parity_err(perr[0]), .frame_err(ferr[0]),
    .overrun(ovr[0]), .busy(busy[0]));

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clock(clock), .reset(reset), .rx(rx_line[1]), .sample_tick(sample_tick), .rx_ack(ack[1]),
    .rx_data(d1), .rx_valid(valid[1]), .parity_err(perr[1]), .frame_err(ferr[1]),
    .overrun(ovr[1]), .busy(busy[1]));

  uart_rx_core #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clock(clock), .reset(reset), .rx(rx_line[2]), .sample_tick(sample_tick), .rx_ack(ack[2]),
    .rx_data(d2), .rx_valid(valid[2]), .parity_err(perr[2]), .frame_err(ferr[2]),
    .overrun(ovr[2]), .busy(busy[2]));

  int os_c[3]  = '{16, 8, 16};
  int db_c[3]  = '{8, 8, 9};
  int pen_c[3] = '{0, 1, 1};
  int pod_c[3] = '{0, 0, 1};
  int sb_c[3]  = '{1, 1, 2};

  int errors = 0;
  int checks = 0;

  // Entry: {channel[1:0], busy_after, overrun, frame_err, parity_err, data[8:0]}
  logic [14:0] exp_q[$];

  logic [2:0] pv = '0, po = '0, pb = '0;
  int ack_cnt[3] = '{0, 0, 0};

  function automatic logic [8:0] data_of(input int ch);
    case (ch)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return d2;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clock iff sample_tick);
    #1;
  endtask

  // Serial driver with the reference model: expected word derived from the frame rules.
  task automatic send_frame(input int ch, input logic [8:0] d, input logic pbit,
                            input logic s0, input logic s1, input logic exp_ovr, input int hold);
    logic [8:0] m;
    logic fin, fe, pe;
    int os;
    os  = os_c[ch];
    m   = 9'(int'(d) & ((1 << db_c[ch]) - 1));
    fin = (sb_c[ch] == 2) ? s1 : s0;
    fe  = !s0 || (sb_c[ch] == 2 && !s1);
    pe  = (pen_c[ch] != 0) ? ((^m) ^ pbit ^ pod_c[ch][0]) : 1'b0;
    exp_q.push_back({2'(ch), !fin, exp_ovr, fe, pe, m});
    rx_line[ch] = 1'b0;
    wait_ticks(os);
    for (int i = 0; i < db_c[ch]; i++) begin
      rx_line[ch] = m[i];
      wait_ticks(os);
    end
    if (pen_c[ch] != 0) begin
      rx_line[ch] = pbit;
      wait_ticks(os);
    end
    rx_line[ch] = s0;
    wait_ticks(os);
    if (sb_c[ch] == 2) begin
      rx_line[ch] = s1;
      wait_ticks(os);
    end
    if (!fin) begin
      wait_ticks(hold / 2);
      check($sformatf("ch%0d busy during break", ch), 32'(busy[ch]), 32'd1);
      wait_ticks(hold - hold / 2);
    end
    rx_line[ch] = 1'b1;
    wait_ticks(2 * os);
  endtask

  task automatic random_frames(input int ch, input int n);
    logic s0, s1;
    for (int k = 0; k < n; k++) begin
      s0 = ($urandom_range(0, 3) != 0);
      s1 = ($urandom_range(0, 3) != 0);
      send_frame(ch, 9'($urandom), 1'($urandom), s0, s1, 1'b0, 3 * os_c[ch]);
    end
  endtask

  // Oversample enable: one-cycle pulse every 3..5 clocks.
  initial begin
    sample_tick = 1'b0;
    forever begin
      repeat ($urandom_range(2, 4)) @(posedge clock);
      #1 sample_tick = 1'b1;
      @(posedge clock);
      #1 sample_tick = 1'b0;
    end
  end

  // Monitor: a new word is a rising rx_valid, or a rising overrun while rx_valid stays high.
  initial begin
    logic [14:0] e;
    ack_auto = '0;
    forever begin
      @(negedge clock);
      for (int ch = 0; ch < 3; ch++) begin
        ack_auto[ch] = 1'b0;
        if (ack_cnt[ch] > 0) begin
          ack_cnt[ch]--;
          if (ack_cnt[ch] == 0) ack_auto[ch] = 1'b1;
        end
        if ((valid[ch] && !pv[ch]) || (ovr[ch] && !po[ch])) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL ch%0d unexpected word: got data 0x%0h expected no word", ch, data_of(ch));
          end else begin
            e = exp_q.pop_front();
            check($sformatf("ch%0d word {ch,busy_before,busy,ovr,ferr,perr,data}", ch),
                  32'({2'(ch), pb[ch], busy[ch], ovr[ch], ferr[ch], perr[ch], data_of(ch)}),
                  32'({e[14:13], 1'b1, e[12:0]}));
            if (ack_en[ch]) ack_cnt[ch] = $urandom_range(1, 3);
          end
        end
        pv[ch] = valid[ch];
        po[ch] = ovr[ch];
        pb[ch] = busy[ch];
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    rx_line = 3'b111;
    ack_man = '0;
    ack_en  = 3'b111;
    repeat (5) @(negedge clock);
    for (int ch = 0; ch < 3; ch++)
      check($sformatf("ch%0d reset outputs", ch),
            32'({data_of(ch), valid[ch], perr[ch], ferr[ch], ovr[ch], busy[ch]}), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    ack_man[0] = 1'b1;
    @(negedge clock);
    ack_man[0] = 1'b0;
    @(negedge clock);
    check("ch0 ack while idle {valid,ovr}", 32'({valid[0], ovr[0]}), 32'd0);

    send_frame(0, 9'h05A, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    check("ch0 busy after 0x5A", 32'(busy[0]), 32'd0);
    random_frames(0, 5);

    rx_line[0] = 1'b0;
    wait_ticks(5);
    rx_line[0] = 1'b1;
    wait_ticks(8);
    check("ch0 glitch {busy,valid}", 32'({busy[0], valid[0]}), 32'd0);

    send_frame(0, 9'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 40);
    check("ch0 busy after break release", 32'(busy[0]), 32'd0);

    ack_en[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    send_frame(0, 9'h022, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    check("ch0 pending {valid,ovr,data}", 32'({valid[0], ovr[0], d0}), 32'h322);
    @(negedge clock);
    ack_man[0] = 1'b1;
    @(negedge clock);
    ack_man[0] = 1'b0;
    check("ch0 after ack {valid,ovr,data}", 32'({valid[0], ovr[0], d0}), 32'h022);
    ack_en[0] = 1'b1;

    rx_line[0] = 1'b0;
    wait_ticks(3 * 16);
    @(negedge clock);
    reset      = 1'b0;
    rx_line[0] = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    wait_ticks(32);
    check("ch0 after mid-frame reset {busy,valid}", 32'({busy[0], valid[0]}), 32'd0);
    send_frame(0, 9'h0C3, 1'b0, 1'b1, 1'b1, 1'b0, 0);

    send_frame(1, 9'h003, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    send_frame(1, 9'h003, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    random_frames(1, 5);

    send_frame(2, 9'h1A5, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    send_frame(2, 9'h1A5, 1'b0, 1'b1, 1'b0, 1'b0, 48);
    send_frame(2, 9'h0F0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    random_frames(2, 5);

    repeat (20) @(negedge clock);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
